// File: rtl/mine_pkg.sv
// Shared types and helpers for the mine placement sequencer.
package mine_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, STEP, READ, TEST, DONE} state_t;

    typedef logic [7:0] cell_addr_t;

    localparam logic [7:0] DEFAULT_SEED = 8'h1F;

    function automatic int cells(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/mine_placer.sv
// Clears the board RAM, then steps the external LFSR and writes MINES unique,
// on-board mines that avoid the first-click cell.
module mine_placer
    import mine_pkg::*;
#(
    parameter int         ROWS      = 8,
    parameter int         COLS      = 8,
    parameter int         MINES     = 10,
    parameter logic [7:0] SEED      = DEFAULT_SEED,
    parameter int         MAX_DRAWS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] safe_addr,
    input  logic       seed_valid,
    input  logic [7:0] seed,
    output logic       lfsr_load,
    output logic [7:0] lfsr_seed,
    output logic       lfsr_en,
    input  logic [7:0] lfsr_data,
    output logic [7:0] mem_addr,
    output logic       mem_re,
    input  logic       mem_rdata,
    output logic       mem_we,
    output logic       mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] mine_count
);

    localparam int CELLS = cells(ROWS, COLS);
    localparam int DW    = $clog2(MAX_DRAWS + 1);
    localparam logic [DW-1:0] DRAW_LIMIT = DW'(MAX_DRAWS);
    localparam cell_addr_t    LAST_CELL  = cell_addr_t'(CELLS - 1);
    localparam logic [7:0]    LAST_MINE  = 8'(MINES - 1);

    if (CELLS > 255) begin : g_cells_chk
        $error("mine_placer: ROWS*COLS must be <= 255");
    end
    if (MINES < 1 || MINES >= CELLS) begin : g_mines_chk
        $error("mine_placer: MINES must be in 1..CELLS-1");
    end

    state_t        state, state_next;
    cell_addr_t    clr_addr;
    cell_addr_t    safe_q;
    cell_addr_t    cand_q;
    cell_addr_t    cand;
    logic          cand_ok;
    logic [DW-1:0] draws;

    // LFSR never yields 0, so its 1..255 range maps onto cells 0..254.
    always_comb begin
        cand    = lfsr_data - 8'd1;
        cand_ok = (int'(cand) < CELLS) && (cand != safe_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_addr   <= '0;
            safe_q     <= '0;
            cand_q     <= '0;
            draws      <= '0;
            mine_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        safe_q     <= safe_addr;
                        mine_count <= '0;
                        draws      <= '0;
                        clr_addr   <= '0;
                    end
                end
                CLEAR: clr_addr <= clr_addr + 8'd1;
                STEP: begin
                    if (draws != DRAW_LIMIT) draws <= draws + DW'(1);
                end
                READ: cand_q <= cand;
                TEST: begin
                    if (!mem_rdata) mine_count <= mine_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_seed  = '0;
        lfsr_en    = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (seed_valid) begin
                    lfsr_load = 1'b1;
                    lfsr_seed = (seed == 8'd0) ? SEED : seed;
                end
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                if (clr_addr == LAST_CELL) state_next = STEP;
            end
            STEP: begin
                if (draws == DRAW_LIMIT) begin
                    error      = 1'b1;
                    state_next = IDLE;
                end else begin
                    lfsr_en    = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (cand_ok) begin
                    mem_addr   = cand;
                    mem_re     = 1'b1;
                    state_next = TEST;
                end else begin
                    state_next = STEP;
                end
            end
            TEST: begin
                if (mem_rdata) begin
                    state_next = STEP;
                end else begin
                    mem_we     = 1'b1;
                    mem_wdata  = 1'b1;
                    mem_addr   = cand_q;
                    state_next = (mine_count == LAST_MINE) ? DONE : STEP;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer with an LFSR model and 1-cycle-latency board RAMs.
module tb_mine_placer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, seed_valid;
    logic [7:0] safe_addr, seed;
    logic       lfsr_load, lfsr_en, mem_re, mem_we, mem_wdata, busy, done, error;
    logic [7:0] lfsr_seed, lfsr_data, mem_addr, mine_count;
    logic       mem_rdata;

    logic       start2, seed_valid2;
    logic [7:0] safe_addr2, seed2;
    logic       lfsr_load2, lfsr_en2, mem_re2, mem_we2, mem_wdata2, busy2, done2, error2;
    logic [7:0] lfsr_seed2, lfsr_data2, mem_addr2, mine_count2;
    logic       mem_rdata2;

    mine_placer u_dut (
        .clk(clk), .rst(rst), .start(start), .safe_addr(safe_addr),
        .seed_valid(seed_valid), .seed(seed), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .lfsr_en(lfsr_en), .lfsr_data(lfsr_data), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .mine_count(mine_count)
    );

    mine_placer #(.ROWS(8), .COLS(8), .MINES(63), .MAX_DRAWS(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .safe_addr(safe_addr2),
        .seed_valid(seed_valid2), .seed(seed2), .lfsr_load(lfsr_load2), .lfsr_seed(lfsr_seed2),
        .lfsr_en(lfsr_en2), .lfsr_data(lfsr_data2), .mem_addr(mem_addr2), .mem_re(mem_re2),
        .mem_rdata(mem_rdata2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .busy(busy2),
        .done(done2), .error(error2), .mine_count(mine_count2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // LFSR / RAM models
    logic [7:0] lfsr_q = 8'h01;
    logic [7:0] lfsr_q2 = 8'h01;
    logic       ram  [0:255];
    logic       ram2 [0:255];
    logic       fill = 1'b0;
    logic       force_mode = 1'b0;
    int         fidx = 0;
    int         fbase = 0;
    logic [7:0] ftab [16];

    always @(posedge clk) begin
        if (lfsr_load) lfsr_q <= lfsr_seed;
        else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
        if (lfsr_en) fidx <= fidx + 1;
        if (lfsr_load2) lfsr_q2 <= lfsr_seed2;
        else if (lfsr_en2) lfsr_q2 <= lfsr_next(lfsr_q2);
        if (fill) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]  <= 1'b1;
                ram2[i] <= 1'b1;
            end
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_re2) mem_rdata2 <= ram2[mem_addr2];
    end

    always_comb begin
        int k;
        k = fidx - fbase;
        lfsr_data = lfsr_q;
        if (force_mode) lfsr_data = (k >= 0 && k < 16) ? ftab[k] : 8'h80;
    end
    assign lfsr_data2 = lfsr_q2;

    // Negedge monitor
    int   cyc = 0;
    int   en_q [$];
    int   mc_q [$];
    int   nclr = 0, nmw = 0, ndone = 0, nerr = 0;
    int   nen2 = 0, nmw2 = 0, ndone2 = 0;
    logic [7:0] cur_safe = 8'd0;
    logic [7:0] want_addr;

    always @(negedge clk) begin
        cyc++;
        if (lfsr_en) begin
            en_q.push_back(cyc);
            mc_q.push_back(int'(mine_count));
        end
        if (busy) check("we_re_excl", {31'd0, mem_we & mem_re}, 32'd0);
        if (mem_we && !mem_wdata) nclr++;
        if (mem_we && mem_wdata) begin
            nmw++;
            want_addr = lfsr_data - 8'd1;
            check("mine_addr", {24'd0, mem_addr}, {24'd0, want_addr});
            check("mine_legal", {31'd0, (mem_addr != cur_safe) && (mem_addr < 8'd64)}, 32'd1);
        end
        if (done) ndone++;
        if (error) nerr++;
        if (lfsr_en2) nen2++;
        if (mem_we2 && mem_wdata2) nmw2++;
        if (done2) ndone2++;
    end

    function automatic int popcnt();
        int s = 0;
        for (int i = 0; i < 64; i++) s += int'(ram[i]);
        return s;
    endfunction

    task automatic do_fill();
        @(negedge clk) fill = 1'b1;
        @(negedge clk) fill = 1'b0;
    endtask

    task automatic run_game(input logic [7:0] sa, input logic sv, input logic [7:0] sd,
                            input bit poke);
        bit got_done = 0;
        @(negedge clk);
        start = 1'b1; safe_addr = sa; seed_valid = sv; seed = sd; cur_safe = sa;
        @(negedge clk);
        start = 1'b0; seed_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (poke && i == 5) begin
                seed_valid = 1'b1; seed = 8'h77;
                #1 check("load_busy", {31'd0, lfsr_load}, 32'd0);
                seed_valid = 1'b0;
            end
            start = poke && lfsr_en && (mine_count < 8'd9);
        end
        start = 1'b0;
        check("done_seen", {31'd0, got_done}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sig"}, {26'd0, done, error, mem_we, mem_re, lfsr_en, lfsr_load}, 32'd0);
        check({tag, "_count"}, {24'd0, mine_count}, 32'd0);
        check({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    endtask

    initial begin
        int b, c0, m0, d0;
        ftab = '{8'h80, 8'd1, 8'd6, 8'd1, 8'd200, 8'd65, 8'd64, 8'd2,
                 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10, 8'h80};
        rst = 1'b1; start = 1'b0; seed_valid = 1'b0; safe_addr = '0; seed = '0;
        start2 = 1'b0; seed_valid2 = 1'b0; safe_addr2 = '0; seed2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Seed handling in IDLE
        seed_valid = 1'b1; seed = 8'h00;
        #1 check("seed0_load", {31'd0, lfsr_load}, 32'd1);
        check("seed0_val", {24'd0, lfsr_seed}, 32'h1F);
        seed = 8'h5A;
        #1 check("seed_val", {24'd0, lfsr_seed}, 32'h5A);
        seed_valid = 1'b0;
        #1 check("seed_off", {31'd0, lfsr_load}, 32'd0);

        // Real LFSR game, seed+start together, start poked while busy
        do_fill();
        c0 = nclr; m0 = nmw; d0 = ndone;
        run_game(8'd0, 1'b1, 8'h1F, 1'b1);
        repeat (3) @(negedge clk);
        check("g1_clears", nclr - c0, 64);
        check("g1_mines", nmw - m0, 10);
        check("g1_dones", ndone - d0, 1);
        check("g1_count", {24'd0, mine_count}, 32'd10);
        check("g1_pop", popcnt(), 10);
        check("g1_safe", {31'd0, ram[0]}, 32'd0);
        check("g1_busy", {31'd0, busy}, 32'd0);

        // Forced draws: safe cell, duplicate, off-board, boundary
        do_fill();
        force_mode = 1'b1; fbase = fidx;
        b = en_q.size(); m0 = nmw;
        run_game(8'd5, 1'b0, 8'h00, 1'b0);
        force_mode = 1'b0;
        check("g2_draws", en_q.size() - b, 14);
        if (en_q.size() - b >= 8) begin
            check("g2_acc_cost", en_q[b+1] - en_q[b], 3);
            check("g2_safe_cost", en_q[b+2] - en_q[b+1], 2);
            check("g2_dup_cost", en_q[b+3] - en_q[b+2], 3);
            check("g2_off_cost", en_q[b+4] - en_q[b+3], 2);
            check("g2_edge_cost", en_q[b+5] - en_q[b+4], 2);
            check("g2_count_hold", mc_q[b+5], 1);
            check("g2_count_next", mc_q[b+6], 2);
        end
        check("g2_mines", nmw - m0, 10);
        check("g2_pop", popcnt(), 10);
        check("g2_safe", {31'd0, ram[5]}, 32'd0);
        check("g2_last", {31'd0, ram[63]}, 32'd1);
        check("g2_count", {24'd0, mine_count}, 32'd10);

        // Abort after MAX_DRAWS on second instance
        @(negedge clk);
        start2 = 1'b1; seed_valid2 = 1'b1; seed2 = 8'h00; safe_addr2 = 8'd0;
        @(negedge clk);
        start2 = 1'b0; seed_valid2 = 1'b0;
        begin
            bit got_err = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (error2) begin
                    got_err = 1;
                    break;
                end
            end
            check("g5_error", {31'd0, got_err}, 32'd1);
        end
        check("g5_draws", nen2, 16);
        check("g5_partial", {24'd0, mine_count2}, nmw2);
        @(negedge clk);
        check("g5_err_pulse", {31'd0, error2}, 32'd0);
        check("g5_busy", {31'd0, busy2}, 32'd0);
        repeat (3) @(negedge clk);
        check("g5_no_done", ndone2, 0);
        check("g5_hold", {24'd0, mine_count2}, nmw2);

        // Reset in TEST, then a fresh game
        @(negedge clk);
        start = 1'b1; safe_addr = 8'd0; cur_safe = 8'd0;
        @(negedge clk);
        start = 1'b0;
        begin
            bit got_re = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (mem_re) begin
                    got_re = 1;
                    break;
                end
            end
            check("g6_read_seen", {31'd0, got_re}, 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("g6_rst");
        rst = 1'b0;
        do_fill();
        c0 = nclr; m0 = nmw;
        run_game(8'd0, 1'b0, 8'h00, 1'b0);
        check("g6_clears", nclr - c0, 64);
        check("g6_mines", nmw - m0, 10);
        check("g6_pop", popcnt(), 10);
        check("g6_count", {24'd0, mine_count}, 32'd10);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
